sram_bus_arbiter: RTL and testbench

Parametrised arbiter that lets NUM_PORTS pipeline requesters share one synchronous SRAM port. Typical requesters are the IF stage and the MEM stage of the five-stage core. It replaces the split instruction-ROM/data-RAM wiring at the CPU top level with a single unified memory. It serialises accesses, supports programmable wait states, returns read data per port, and raises per-port stall requests into ctrl.

---
 rtl/sram_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: lets NUM_PORTS pipeline requesters share one synchronous
// SRAM port. Accesses are serialised, each takes WAIT_CYCLES+1 bus cycles, and
// completions are pipelined so a pending requester is granted with no bubble.
// Port 0 has the highest fixed priority. Define ARB_ROUND_ROBIN_EN to rotate
// priority with a pointer that moves past each granted port.
//
// state  | meaning
// IDLE   | bus free, mem_* driven to zero
// ACCESS | SRAM cycle in progress for grant_q, wait counter running
module sram_bus_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_ce,
  input  logic [NUM_PORTS-1:0]          req_we,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_sel,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [NUM_PORTS-1:0]          stallreq,
  output logic                          mem_ce,
  output logic                          mem_we,
  output logic [DATA_W/8-1:0]           mem_sel,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);
  localparam int SEL_W = DATA_W / 8;
  localparam int GW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        pick_idx;
  logic                 pick_valid;
  logic                 load;
  logic                 done;
  logic [3:0]           wait_cnt;
  logic [NUM_PORTS-1:0] elig;

  assign stallreq = req_ce & ~rsp_valid;
  assign done     = (state_q == ACCESS) && (wait_cnt == 4'(WAIT_CYCLES));

  // A port whose pulse is out, or whose access is completing now, still shows
  // its old req_ce; masking it prevents serving the same request twice.
  always_comb begin
    elig = req_ce & ~rsp_valid;
    if (done) elig[grant_q] = 1'b0;
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0]        ptr_q;
  logic [NUM_PORTS-1:0] rot;

  // Winner is the first eligible port at or after the pointer, wrapping.
  always_comb begin
    rot        = NUM_PORTS'({elig, elig} >> ptr_q);
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'((int'(ptr_q) + k) % NUM_PORTS);
      end
    end
  end

  // Priority pointer moves just past each granted port.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (load) ptr_q <= (pick_idx == GW'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
  end
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'(i);
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and grant strobe; a completion with a pending port re-grants.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          load    = 1'b1;
        end
      end
      ACCESS: begin
        if (done) begin
          if (pick_valid) load = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM bus, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= '0;
      wait_cnt  <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (done && req_ce[grant_q]) begin
        rsp_valid[grant_q] <= 1'b1;
        if (!mem_we) rsp_rdata <= mem_rdata;
      end
      if (load) begin
        grant_q   <= pick_idx;
        wait_cnt  <= '0;
        mem_ce    <= 1'b1;
        mem_we    <= req_we[pick_idx];
        mem_sel   <= req_sel[int'(pick_idx)*SEL_W +: SEL_W];
        mem_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        mem_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
      end else if (done) begin
        wait_cnt  <= '0;
        mem_ce    <= 1'b0;
        mem_we    <= 1'b0;
        mem_sel   <= '0;
        mem_addr  <= '0;
        mem_wdata <= '0;
      end else if (state_q == ACCESS) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed vectors, responses checked through a
// scoreboard queue drained by a negedge monitor. A second instance runs with
// three wait states. Expected ordering follows ARB_ROUND_ROBIN_EN when defined.
module tb_sram_bus_arbiter;
  logic        clk;
  logic        rst;
  logic [1:0]  req_ce, req_we;
  logic [7:0]  req_sel;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  rsp_valid, stallreq;
  logic [31:0] rsp_rdata;
  logic        mem_ce, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [1:0]  w_req_ce;
  logic [63:0] w_req_addr;
  logic [1:0]  w_rsp_valid, w_stallreq;
  logic [31:0] w_rsp_rdata;
  logic        w_mem_ce, w_mem_we;
  logic [3:0]  w_mem_sel;
  logic [31:0] w_mem_addr, w_mem_wdata, w_mem_rdata;

  logic [31:0] ram [0:63];

  typedef struct {
    int          port;
    logic [31:0] rdata;
    bit          is_wr;
  } exp_t;
  exp_t sb_q[$];
  logic [31:0] prev_exp;

  int checks = 0;
  int errors = 0;

  sram_bus_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .req_ce(req_ce), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .stallreq(stallreq), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  sram_bus_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req_ce(w_req_ce), .req_we(2'b00), .req_sel(8'hFF),
    .req_addr(w_req_addr), .req_wdata(64'd0), .rsp_valid(w_rsp_valid),
    .rsp_rdata(w_rsp_rdata), .stallreq(w_stallreq), .mem_ce(w_mem_ce), .mem_we(w_mem_we),
    .mem_sel(w_mem_sel), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: read presents the addressed word, writes commit on the edge.
  assign mem_rdata   = ram[mem_addr[7:2]];
  assign w_mem_rdata = {16'hBEEF, w_mem_addr[15:0]};

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 | i;
    end else if (mem_ce && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_sel[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int port, input logic [31:0] rdata, input bit is_wr);
    exp_t e;
    e.port = port; e.rdata = rdata; e.is_wr = is_wr;
    sb_q.push_back(e);
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] want;
    if (rst) begin
      prev_exp = 32'd0;
    end else if (rsp_valid != 2'b00) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid %b expected no response at %0t", rsp_valid, $time);
      end else begin
        e = sb_q.pop_front();
        want = e.is_wr ? prev_exp : e.rdata;
        chk("rsp_port", {62'd0, rsp_valid}, 64'd1 << e.port);
        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, want});
        prev_exp = want;
      end
    end
  end

  int first_p;
  logic [31:0] first_a, second_a;

  initial begin
    rst = 1'b1; req_ce = '0; req_we = '0; req_sel = '0; req_addr = '0; req_wdata = '0;
    w_req_ce = '0; w_req_addr = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_ce", {63'd0, mem_ce}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    tick(); rst = 1'b0;
    tick();

    // Single read by port 1.
    req_addr[32 +: 32] = 32'h10; req_sel[4 +: 4] = 4'hF; req_we[1] = 1'b0; req_ce[1] = 1'b1;
    push(1, 32'h1000_0004, 1'b0);
    @(negedge clk);
    chk("t1_c0_stall", {62'd0, stallreq}, 64'b10);
    chk("t1_c0_mem_ce", {63'd0, mem_ce}, 64'd0);
    tick(); @(negedge clk);
    chk("t1_c1_mem_ce", {63'd0, mem_ce}, 64'd1);
    chk("t1_c1_addr", {32'd0, mem_addr}, 64'h10);
    chk("t1_c1_stall", {62'd0, stallreq}, 64'b10);
    tick(); @(negedge clk);
    chk("t1_c2_stall", {62'd0, stallreq}, 64'b00);
    chk("t1_c2_mem_ce", {63'd0, mem_ce}, 64'd0);
    tick(); req_ce[1] = 1'b0;
    @(negedge clk);
    chk("t1_c3_mem_ce", {63'd0, mem_ce}, 64'd0);

    // Same-cycle requests: port 0 write first, port 1 back-to-back.
    tick();
    req_addr[0 +: 32] = 32'h20; req_wdata[0 +: 32] = 32'hDEADBEEF; req_sel[0 +: 4] = 4'hF;
    req_we[0] = 1'b1; req_ce[0] = 1'b1;
    req_addr[32 +: 32] = 32'h24; req_we[1] = 1'b0; req_ce[1] = 1'b1;
    push(0, 32'h0, 1'b1);
    push(1, 32'h1000_0009, 1'b0);
    @(negedge clk);
    chk("t2_c0_stall", {62'd0, stallreq}, 64'b11);
    tick(); @(negedge clk);
    chk("t2_c1_addr", {32'd0, mem_addr}, 64'h20);
    chk("t2_c1_we", {63'd0, mem_we}, 64'd1);
    chk("t2_c1_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    chk("t2_c1_stall1", {63'd0, stallreq[1]}, 64'd1);
    tick(); @(negedge clk);
    chk("t2_c2_mem_ce", {63'd0, mem_ce}, 64'd1);
    chk("t2_c2_addr", {32'd0, mem_addr}, 64'h24);
    chk("t2_c2_we", {63'd0, mem_we}, 64'd0);
    chk("t2_c2_stall", {62'd0, stallreq}, 64'b10);
    tick(); req_ce[0] = 1'b0;
    @(negedge clk);
    chk("t2_c3_stall", {62'd0, stallreq}, 64'b00);
    chk("t2_c3_mem_ce", {63'd0, mem_ce}, 64'd0);
    tick(); req_ce[1] = 1'b0;
    chk("t2_ram_write", {32'd0, ram[8]}, 64'hDEADBEEF);

    // Port 1 withdraws a write mid-access; port 0 is granted at completion.
    tick();
    req_addr[32 +: 32] = 32'h30; req_wdata[32 +: 32] = 32'h1234_5678; req_sel[4 +: 4] = 4'hF;
    req_we[1] = 1'b1; req_ce[1] = 1'b1;
    tick();
    req_ce[1] = 1'b0;
    req_addr[0 +: 32] = 32'h34; req_we[0] = 1'b0; req_ce[0] = 1'b1;
    push(0, 32'h1000_000D, 1'b0);
    @(negedge clk);
    chk("t3_c1_addr", {32'd0, mem_addr}, 64'h30);
    chk("t3_c1_we", {63'd0, mem_we}, 64'd1);
    tick(); @(negedge clk);
    chk("t3_c2_addr", {32'd0, mem_addr}, 64'h34);
    chk("t3_c2_mem_ce", {63'd0, mem_ce}, 64'd1);
    chk("t3_c2_rsp", {62'd0, rsp_valid}, 64'd0);
    chk("t3_ram_write", {32'd0, ram[12]}, 64'h1234_5678);
    tick(); tick(); req_ce[0] = 1'b0; req_we[1] = 1'b0;

    // Reset during an access, then a fresh request.
    tick();
    req_addr[0 +: 32] = 32'h40; req_ce[0] = 1'b1;
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("t4_c1_mem_ce", {63'd0, mem_ce}, 64'd1);
    tick(); @(negedge clk);
    chk("t4_rst_mem_ce", {63'd0, mem_ce}, 64'd0);
    chk("t4_rst_addr", {32'd0, mem_addr}, 64'd0);
    chk("t4_rst_we", {63'd0, mem_we}, 64'd0);
    chk("t4_rst_rsp", {62'd0, rsp_valid}, 64'd0);
    chk("t4_rst_rdata", {32'd0, rsp_rdata}, 64'd0);
    rst = 1'b0; req_addr[0 +: 32] = 32'h44;
    push(0, 32'h1000_0011, 1'b0);
    tick(); @(negedge clk);
    chk("t4_new_addr", {32'd0, mem_addr}, 64'h44);
    chk("t4_new_mem_ce", {63'd0, mem_ce}, 64'd1);
    tick(); tick(); req_ce[0] = 1'b0;

    // Arbitration order after port 0 was last served.
    tick();
    req_addr[0 +: 32] = 32'h50; req_ce[0] = 1'b1;
    push(0, 32'h1000_0014, 1'b0);
    tick(); tick(); tick();
    req_addr[0 +: 32] = 32'h54; req_addr[32 +: 32] = 32'h58; req_we = 2'b00; req_ce = 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
    first_p = 1; first_a = 32'h58; second_a = 32'h54;
    push(1, 32'h1000_0016, 1'b0);
    push(0, 32'h1000_0015, 1'b0);
`else
    first_p = 0; first_a = 32'h54; second_a = 32'h58;
    push(0, 32'h1000_0015, 1'b0);
    push(1, 32'h1000_0016, 1'b0);
`endif
    tick(); @(negedge clk);
    chk("t5_first_addr", {32'd0, mem_addr}, {32'd0, first_a});
    tick(); @(negedge clk);
    chk("t5_second_addr", {32'd0, mem_addr}, {32'd0, second_a});
    tick(); req_ce[first_p] = 1'b0;
    tick(); req_ce = 2'b00;
    tick();

    // Three wait states: bus held four cycles, response five after request.
    w_req_addr[32 +: 32] = 32'h80; w_req_ce = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      tick(); @(negedge clk);
      chk("w3_mem_ce", {63'd0, w_mem_ce}, 64'd1);
      chk("w3_mem_addr", {32'd0, w_mem_addr}, 64'h80);
      chk("w3_no_rsp", {62'd0, w_rsp_valid}, 64'd0);
    end
    tick(); @(negedge clk);
    chk("w3_rsp_valid", {62'd0, w_rsp_valid}, 64'b10);
    chk("w3_rsp_rdata", {32'd0, w_rsp_rdata}, 64'hBEEF0080);
    chk("w3_mem_ce_drop", {63'd0, w_mem_ce}, 64'd0);
    tick(); w_req_ce = 2'b00;
    tick(); @(negedge clk);
    chk("w3_idle", {63'd0, w_mem_ce}, 64'd0);

    tick(); tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
